// File: rtl/pdh_dac_out_if.sv
// Actuator-word streams into the DAC output stage and the packed AXI-Stream out to the DAC.
interface pdh_dac_out_if #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic signed [DAC_DATA_WIDTH-1:0] ctrl_a_tdata;
  logic                             ctrl_a_tvalid;
  logic signed [DAC_DATA_WIDTH-1:0] ctrl_b_tdata;
  logic                             ctrl_b_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0]      M_AXIS_tdata;
  logic                             M_AXIS_tvalid;

  modport slave (
    input  ctrl_a_tdata, ctrl_a_tvalid, ctrl_b_tdata, ctrl_b_tvalid,
    output M_AXIS_tdata, M_AXIS_tvalid
  );

  modport master (
    output ctrl_a_tdata, ctrl_a_tvalid, ctrl_b_tdata, ctrl_b_tvalid,
    input  M_AXIS_tdata, M_AXIS_tvalid
  );
endinterface

// File: rtl/pdh_dac_out.sv
// DAC output stage: clamp, slew-limit and safe-disable ramp per channel, packed into a
// free-running 32-bit AXI-Stream with sticky saturation flags.

module pdh_dac_lane #(
  parameter int W = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] din,
  input  logic                din_vld,
  input  logic                enable,
  input  logic                hold,
  input  logic                clr_flags,
  input  logic [W-1:0]        step,
  input  logic signed [W-1:0] win_hi,
  input  logic signed [W-1:0] win_lo,
  output logic signed [W-1:0] cur,
  output logic                busy,
  output logic                sat
);
  logic signed [W-1:0] tgt, tgt_nxt, cur_nxt, clamped;
  logic signed [W:0]   diff;
  logic [W:0]          mag;
  logic                oor;

  always_comb begin
    oor     = (din > win_hi) || (din < win_lo);
    clamped = din;
    if (din > win_hi)      clamped = win_hi;
    else if (din < win_lo) clamped = win_lo;

    tgt_nxt = tgt;
    if (!enable)      tgt_nxt = '0;
    else if (din_vld) tgt_nxt = clamped;

    // 15-bit difference cannot overflow; the partial step always lands between cur and tgt
    diff = {tgt[W-1], tgt} - {cur[W-1], cur};
    mag  = diff[W] ? -diff : diff;

    cur_nxt = cur;
    if (!hold) begin
      if (step == '0 || mag <= {1'b0, step}) cur_nxt = tgt;
      else if (diff[W])                       cur_nxt = cur - step;
      else                                    cur_nxt = cur + step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt  <= '0;
      cur  <= '0;
      busy <= 1'b0;
      sat  <= 1'b0;
    end else begin
      tgt  <= tgt_nxt;
      cur  <= cur_nxt;
      busy <= (cur_nxt != tgt_nxt);
      if (din_vld && enable && oor) sat <= 1'b1;
      else if (clr_flags)           sat <= 1'b0;
    end
  end
endmodule

module pdh_dac_out #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  pdh_dac_out_if.slave                     bus,
  input  logic                             enable,
  input  logic                             hold,
  input  logic [DAC_DATA_WIDTH-1:0]        slew_step,
  input  logic signed [DAC_DATA_WIDTH-1:0] clamp_hi,
  input  logic signed [DAC_DATA_WIDTH-1:0] clamp_lo,
  input  logic                             clr_flags,
  output logic                             sat_a,
  output logic                             sat_b,
  output logic                             busy_a,
  output logic                             busy_b,
  output logic                             cfg_err
);
  localparam int W         = DAC_DATA_WIDTH;
  localparam int NUM_LANES = 2;
  localparam int LANE_W    = AXIS_TDATA_WIDTH / NUM_LANES;

  logic signed [W-1:0] hi_q, lo_q, win_hi, win_lo;
  logic [W-1:0]        step_q;
  logic                cfg_err_q;

  logic [NUM_LANES-1:0][W-1:0]      din, cur;
  logic [NUM_LANES-1:0]             din_vld, busy, sat;
  logic [NUM_LANES-1:0][LANE_W-1:0] dout_nxt;
  logic [AXIS_TDATA_WIDTH-1:0]      dout_q;
  logic                             tvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      step_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      hi_q      <= clamp_hi;
      lo_q      <= clamp_lo;
      step_q    <= slew_step;
      cfg_err_q <= (clamp_lo > clamp_hi);
    end
  end

  // An inverted window collapses to [0,0] so a misconfigured PS can only park the DAC
  assign win_hi = cfg_err_q ? '0 : hi_q;
  assign win_lo = cfg_err_q ? '0 : lo_q;

  assign din[0]     = bus.ctrl_a_tdata;
  assign din[1]     = bus.ctrl_b_tdata;
  assign din_vld[0] = bus.ctrl_a_tvalid;
  assign din_vld[1] = bus.ctrl_b_tvalid;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic signed [W-1:0] cur_s;
    pdh_dac_lane #(.W(W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din[g]),
      .din_vld   (din_vld[g]),
      .enable    (enable),
      .hold      (hold),
      .clr_flags (clr_flags),
      .step      (step_q),
      .win_hi    (win_hi),
      .win_lo    (win_lo),
      .cur       (cur_s),
      .busy      (busy[g]),
      .sat       (sat[g])
    );
    assign cur[g]      = cur_s;
    assign dout_nxt[g] = {{(LANE_W-W){cur_s[W-1]}}, cur_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_nxt;
      tvalid_q <= 1'b1;
    end
  end

  assign bus.M_AXIS_tdata  = dout_q;
  assign bus.M_AXIS_tvalid = tvalid_q;
  assign sat_a   = sat[0];
  assign sat_b   = sat[1];
  assign busy_a  = busy[0];
  assign busy_b  = busy[1];
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_pdh_dac_out.sv
// Directed bench for pdh_dac_out: reset, latency, slew, clamp/flags, disable ramp, cfg_err, async reset.
module tb_pdh_dac_out;
  logic clk = 1'b0;
  logic rst_n;
  logic enable, hold, clr_flags;
  logic [13:0] slew_step;
  logic signed [13:0] clamp_hi, clamp_lo;
  logic sat_a, sat_b, busy_a, busy_b, cfg_err;
  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt;
  int exp_v;

  pdh_dac_out_if #(.DAC_DATA_WIDTH(14), .AXIS_TDATA_WIDTH(32)) bus ();

  pdh_dac_out #(.DAC_DATA_WIDTH(14), .AXIS_TDATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .enable(enable), .hold(hold), .slew_step(slew_step),
    .clamp_hi(clamp_hi), .clamp_lo(clamp_lo), .clr_flags(clr_flags),
    .sat_a(sat_a), .sat_b(sat_b), .busy_a(busy_a), .busy_b(busy_b), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; hold = 1'b0; clr_flags = 1'b0;
    slew_step = '0; clamp_hi = '0; clamp_lo = '0;
    bus.ctrl_a_tdata = '0; bus.ctrl_a_tvalid = 1'b0;
    bus.ctrl_b_tdata = '0; bus.ctrl_b_tvalid = 1'b0;

    // reset
    #3;
    chk("rst_tdata", bus.M_AXIS_tdata, 32'h0);
    chk("rst_tvalid", {31'b0, bus.M_AXIS_tvalid}, 32'h0);
    tick(); tick();
    chk("rst_tvalid_clk", {31'b0, bus.M_AXIS_tvalid}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("tvalid_after_rst", {31'b0, bus.M_AXIS_tvalid}, 32'h1);
    chk("tdata_after_rst", bus.M_AXIS_tdata, 32'h0);
    chk("flags_after_rst", {27'b0, sat_a, sat_b, busy_a, busy_b, cfg_err}, 32'h0);

    // passthrough latency
    clamp_hi = 14'sd8191; clamp_lo = 14'h2000; slew_step = '0; enable = 1'b1;
    tick();
    bus.ctrl_a_tdata = 14'sd1000; bus.ctrl_a_tvalid = 1'b1;
    bus.ctrl_b_tdata = -14'sd5;   bus.ctrl_b_tvalid = 1'b1;
    tick();
    chk("pt_busy_k", {30'b0, busy_a, busy_b}, 32'h3);
    bus.ctrl_a_tvalid = 1'b0; bus.ctrl_b_tvalid = 1'b0;
    tick();
    chk("pt_tdata_k1", bus.M_AXIS_tdata, 32'h0);
    tick();
    chk("pt_tdata_k2", bus.M_AXIS_tdata, 32'hFFFB_03E8);

    // slew 0 -> 1050, step 100
    bus.ctrl_a_tdata = '0; bus.ctrl_a_tvalid = 1'b1;
    bus.ctrl_b_tdata = '0; bus.ctrl_b_tvalid = 1'b1;
    tick();
    bus.ctrl_a_tvalid = 1'b0; bus.ctrl_b_tvalid = 1'b0;
    tick();
    slew_step = 14'd100;
    tick();
    bus.ctrl_a_tdata = 14'sd1050; bus.ctrl_a_tvalid = 1'b1;
    tick();
    bus.ctrl_a_tvalid = 1'b0;
    busy_cnt = busy_a ? 1 : 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (busy_a) busy_cnt++;
      exp_v = (100 * (j - 1) > 1050) ? 1050 : 100 * (j - 1);
      chk($sformatf("slew_out_%0d", j), {16'b0, bus.M_AXIS_tdata[15:0]}, exp_v);
      chk($sformatf("slew_busy_%0d", j), {31'b0, busy_a}, (j <= 10) ? 32'h1 : 32'h0);
    end
    chk("slew_busy_cycles", busy_cnt, 32'd11);

    // clamp and sticky flags
    clamp_hi = 14'sd2000; clamp_lo = -14'sd1000; slew_step = '0;
    tick();
    bus.ctrl_a_tdata = 14'sd3000; bus.ctrl_a_tvalid = 1'b1;
    tick();
    chk("clamp_sat_set", {30'b0, sat_a, sat_b}, 32'h2);
    bus.ctrl_a_tvalid = 1'b0;
    tick(); tick();
    chk("clamp_hi_out", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'h07D0);
    bus.ctrl_a_tdata = -14'sd2000; bus.ctrl_a_tvalid = 1'b1; clr_flags = 1'b1;
    tick();
    chk("sat_set_wins", {31'b0, sat_a}, 32'h1);
    bus.ctrl_a_tvalid = 1'b0; clr_flags = 1'b0;
    tick(); tick();
    chk("clamp_lo_out", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hFC18);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_cleared", {31'b0, sat_a}, 32'h0);

    // disable ramp from -4000, step 500, hold mid-ramp
    clamp_hi = 14'sd4000; clamp_lo = 14'h2000;
    tick();
    bus.ctrl_a_tdata = -14'sd4000; bus.ctrl_a_tvalid = 1'b1;
    tick();
    bus.ctrl_a_tvalid = 1'b0;
    tick();
    slew_step = 14'd500;
    tick();
    enable = 1'b0; bus.ctrl_a_tdata = 14'sd5000; bus.ctrl_a_tvalid = 1'b1;
    tick();                                   // m
    tick(); tick();                           // m+2
    chk("ramp_m2", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hF254);
    tick();                                   // m+3
    hold = 1'b1;
    tick();
    chk("ramp_m4", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hF63C);
    tick();
    chk("hold_frozen", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hF63C);
    chk("hold_busy", {31'b0, busy_a}, 32'h1);
    hold = 1'b0;
    tick();
    chk("ramp_m6", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hF63C);
    tick();
    chk("ramp_m7", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hF830);
    tick(); tick(); tick();
    chk("ramp_m10", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'hFE0C);
    tick();
    chk("ramp_done", bus.M_AXIS_tdata, 32'h0);
    chk("ramp_flags", {30'b0, busy_a, sat_a}, 32'h0);
    bus.ctrl_a_tvalid = 1'b0; enable = 1'b1;

    // cfg_err collapses the window to [0,0]
    bus.ctrl_a_tdata = 14'sd300; bus.ctrl_a_tvalid = 1'b1;
    tick();
    bus.ctrl_a_tvalid = 1'b0;
    tick(); tick();
    chk("pre_cfgerr_out", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'h012C);
    clamp_lo = 14'sd100; clamp_hi = -14'sd100;
    tick();
    chk("cfg_err_set", {31'b0, cfg_err}, 32'h1);
    bus.ctrl_a_tdata = 14'sd50;  bus.ctrl_a_tvalid = 1'b1;
    bus.ctrl_b_tdata = -14'sd50; bus.ctrl_b_tvalid = 1'b1;
    tick();
    chk("cfgerr_sat", {30'b0, sat_a, sat_b}, 32'h3);
    bus.ctrl_a_tvalid = 1'b0; bus.ctrl_b_tvalid = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("cfgerr_clr", {30'b0, sat_a, sat_b}, 32'h0);
    tick();
    chk("cfgerr_loads0", bus.M_AXIS_tdata, 32'h0);
    bus.ctrl_a_tdata = '0; bus.ctrl_a_tvalid = 1'b1;
    tick();
    bus.ctrl_a_tvalid = 1'b0;
    chk("cfgerr_zero_nosat", {31'b0, sat_a}, 32'h0);

    // asynchronous reset mid-ramp
    clamp_hi = 14'sd8191; clamp_lo = 14'h2000; slew_step = 14'd10;
    tick();
    chk("cfg_err_clear", {31'b0, cfg_err}, 32'h0);
    bus.ctrl_a_tdata = 14'sd1000; bus.ctrl_a_tvalid = 1'b1;
    tick();
    bus.ctrl_a_tvalid = 1'b0;
    repeat (5) tick();
    chk("pre_areset_out", {16'b0, bus.M_AXIS_tdata[15:0]}, 32'h0028);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_tdata", bus.M_AXIS_tdata, 32'h0);
    chk("areset_tvalid", {31'b0, bus.M_AXIS_tvalid}, 32'h0);
    chk("areset_busy", {31'b0, busy_a}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_areset_tvalid", {31'b0, bus.M_AXIS_tvalid}, 32'h1);
    tick();
    chk("post_areset_tdata", bus.M_AXIS_tdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
